// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES key expansion for AES-128/192/256.
// Produces one 32-bit schedule word per clock from a sliding window of
// the last 8 words. Each group of four words is emitted as one 128-bit
// round key.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle request, sampled only while idle
//   algo       2'b00 AES-128, 2'b01 AES-192, 2'b10 AES-256, 2'b11 illegal
//   key_in     left-aligned cipher key (unused LSBs ignored)
//   busy       high while an expansion is running
//   rk_valid   one-cycle strobe, round_key/rk_index valid
//   rk_index   round number of round_key (0..Nr)
//   round_key  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs
//   done       one-cycle strobe with the final rk_valid
//   err        one-cycle strobe on start with the illegal algo code
module key_expansion_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   algo,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done,
  output logic         err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  logic [0:0]   state;
  logic [255:0] key_reg;
  logic [1:0]   algo_reg;
  logic [5:0]   word_cnt;
  logic [2:0]   mod_cnt;
  logic [7:0]   rcon;
  logic [31:0]  win [8];

  logic [2:0]   nk_m1;
  logic [5:0]   nw_m1;
  logic [31:0]  prev_word;
  logic [31:0]  back_word;
  logic [31:0]  rot_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  new_word;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Forward S-box computed rather than tabulated: the multiplicative
  // inverse is x^254 (x^2 * x^4 * ... * x^128, and 0 maps to 0), followed
  // by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int n = 1; n < 8; n++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    case (algo_reg)
      2'b01:   begin nk_m1 = 3'd5; nw_m1 = 6'd51; end
      2'b10:   begin nk_m1 = 3'd7; nw_m1 = 6'd59; end
      default: begin nk_m1 = 3'd3; nw_m1 = 6'd43; end
    endcase
  end

  // win[0] holds w[i-1], and win[k] holds w[i-1-k]. This makes w[i-Nk]
  // equal to win[Nk-1]. mod_cnt tracks i mod Nk, so no divider is needed.
  always_comb begin
    prev_word = win[0];
    back_word = win[nk_m1];
    rot_word  = {prev_word[23:0], prev_word[31:24]};
    sub_in    = (mod_cnt == 3'd0) ? rot_word : prev_word;
    sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                 sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    if (word_cnt <= {3'b000, nk_m1})
      new_word = key_reg[255:224];
    else if (mod_cnt == 3'd0)
      new_word = back_word ^ sub_out ^ {rcon, 24'h000000};
    else if (nk_m1 == 3'd7 && mod_cnt == 3'd4)
      new_word = back_word ^ sub_out;
    else
      new_word = back_word ^ prev_word;
  end

  // key_reg shifts left by one word per cycle. Its top word is therefore
  // always the next key word while i < Nk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      algo_reg  <= 2'b00;
      word_cnt  <= 6'd0;
      mod_cnt   <= 3'd0;
      rcon      <= 8'h00;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      rk_index  <= 4'd0;
      round_key <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int k = 0; k < 8; k++) win[k] <= 32'h0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (algo == 2'b11) begin
            err <= 1'b1;
          end else begin
            state    <= EXPAND;
            busy     <= 1'b1;
            key_reg  <= key_in;
            algo_reg <= algo;
            word_cnt <= 6'd0;
            mod_cnt  <= 3'd0;
            rcon     <= 8'h01;
          end
        end
      end else begin
        win[0] <= new_word;
        for (int k = 1; k < 8; k++) win[k] <= win[k-1];
        key_reg  <= {key_reg[223:0], 32'h0};
        word_cnt <= word_cnt + 6'd1;
        mod_cnt  <= (mod_cnt == nk_m1) ? 3'd0 : mod_cnt + 3'd1;
        if (word_cnt > {3'b000, nk_m1} && mod_cnt == 3'd0)
          rcon <= xtime(rcon);
        if (word_cnt[1:0] == 2'b11) begin
          rk_valid  <= 1'b1;
          rk_index  <= word_cnt[5:2];
          round_key <= {win[2], win[1], win[0], new_word};
        end
        if (word_cnt == nw_m1) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: doc/key_expansion_seq.md
KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; the block SHALL use one clock, with reset asynchronous and active-low.
REQ-003 start  input  1  single-cycle request; sampled only in IDLE.
REQ-004 algo  input  2  2'b00 AES-128, 2'b01 AES-192, 2'b10 AES-256, 2'b11 illegal; sampled with start.
REQ-005 key_in  input  256  cipher key, left-aligned: 128 uses [255:128], 192 uses [255:64], unused LSBs ignored.
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 rk_valid  output  1  one-cycle strobe; round_key/rk_index valid.
REQ-008 rk_index  output  4  round number of round_key, 0..Nr.
REQ-009 round_key  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs.
REQ-010 done  output  1  one-cycle strobe coincident with the final rk_valid.
REQ-011 err  output  1  one-cycle strobe on start with algo=2'b11.

Function
REQ-012 Parameters per algo: Nk=4/6/8, Nr=10/12/14, total words Nw=44/52/60.
REQ-013 FSM states: IDLE, EXPAND; IDLE->EXPAND on start with legal algo; EXPAND->IDLE after word Nw-1 is produced.
REQ-014 On accepted start: key and algo latched; word counter i=0; Rcon register=8'h01; busy rises next cycle.
REQ-015 EXPAND produces exactly one 32-bit word w[i] per cycle, i=0..Nw-1; for i<Nk, w[i] is taken from the latched key.
REQ-016 For i>=Nk: w[i]=w[i-Nk]^temp; temp=SubWord(RotWord(w[i-1]))^{Rcon,24'h0} if i mod Nk==0; temp=SubWord(w[i-1]) if Nk==8 and i mod 8==4; else temp=w[i-1].
REQ-017 SubWord uses four internal AES forward S-box lookups; window storage is a sliding buffer of the last 8 words.
REQ-018 Rcon advances after each use by GF(2^8) xtime (8'h80 -> 8'h1b); it is unused after the final round.
REQ-019 rk_valid asserted in the cycle after w[i] is produced when i mod 4==3, with rk_index=i/4 and round_key=w[i-3..i]; outputs are registered.
REQ-020 Latency: start accepted at edge T; first rk_valid (index 0) at edge T+4; last rk_valid at edge T+Nw; exactly Nr+1 rk_valid pulses per run.
REQ-021 done=1 together with the rk_valid for rk_index=Nr; busy drops in the same cycle done is high; a new start is accepted in the following cycle.
REQ-022 start while busy SHALL be ignored and SHALL NOT disturb the run; key_in/algo changes while busy have no effect.
REQ-023 start with algo=2'b11 in IDLE: remain in IDLE, err=1 for one cycle, no rk_valid.
REQ-024 round_key and rk_index hold their last values between strobes.

Reset
REQ-025 rst_n low at any time, including mid-expansion, forces IDLE immediately; busy, rk_valid, done, err=0; rk_index=0; round_key=0; counter and Rcon cleared.
REQ-026 After rst_n deasserts, the block issues no strobe until a new legal start is accepted.

Verification
REQ-027 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> index0 = key, index1 a0fafe1788542cb123a339392a6c7605, index10 d014f9a8c9ee2589e13f0cc8b6630ca6 with done; 11 pulses total.
REQ-028 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> index12 e98ba06f448c773c8ecc720401002202 with done; 13 pulses; busy high for 52 cycles.
REQ-029 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> index1 1f352c073b6108d72d9810a30914dff4, index14 fe4890d1e6188d0b046df344706c631e with done; 15 pulses.
REQ-030 start re-pulsed at index 5 of an AES-128 run, with a different key -> run completes unchanged, same vectors as REQ-027.
REQ-031 rst_n pulsed low during index 6 of an AES-256 run -> all outputs 0 asynchronously, no further strobes; a subsequent AES-128 start reproduces REQ-027.
REQ-032 start with algo=2'b11 -> err high one cycle, busy stays 0, no rk_valid.
